wb_arbiter: RTL and testbench

- Collects completion results from the execution units (ALU, MUL/DIV, LSU) and serialises them into the single writeback port of the reorder buffer.
- Each unit gets a small per-source FIFO, so completions that land in the same cycle are never lost.
- A round-robin arbiter drains the FIFOs at one result per cycle into a registered writeback bundle.
- Sits between the execution units and the reorder buffer; flushed by the ROB's flush_.

---
 rtl/wb_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_wb_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-source result FIFOs drained round-robin into one
// registered writeback port toward the reorder buffer.
module wb_arbiter #(
    parameter int unsigned DATA          = 32,
    parameter int unsigned ROB_DEPTH     = 16,
    parameter int unsigned ROB           = $clog2(ROB_DEPTH),
    parameter int unsigned SRC           = 3,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned EXP_W         = 4,
    parameter bit          CHK_PUSH_BUSY = 1'b1
) (
    input  logic                           clk,
    input  logic                           reset_,
    input  logic                           flush_,
    input  logic [SRC-1:0]                 src_e_,
    input  logic [SRC-1:0][ROB-1:0]        src_rob_id,
    input  logic [SRC-1:0][DATA-1:0]       src_data,
    input  logic [SRC-1:0]                 src_exp_,
    input  logic [SRC-1:0][EXP_W-1:0]      src_exp_code,
    input  logic [SRC-1:0]                 src_pred_miss_,
    input  logic [SRC-1:0]                 src_jump_miss_,
    output logic [SRC-1:0]                 src_busy,
    output logic                           wb_e_,
    output logic [ROB-1:0]                 wb_rob_id,
    output logic [DATA-1:0]                wb_data,
    output logic                           wb_exp_,
    output logic [EXP_W-1:0]               wb_exp_code,
    output logic                           wb_pred_miss_,
    output logic                           wb_jump_miss_
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SRC_W = (SRC > 1) ? $clog2(SRC) : 1;

    typedef struct packed {
        logic [ROB-1:0]   rob_id;
        logic [DATA-1:0]  data;
        logic             exp_;
        logic [EXP_W-1:0] exp_code;
        logic             pred_miss_;
        logic             jump_miss_;
    } entry_t;

    localparam entry_t WB_RST = '{rob_id: '0, data: '0, exp_: 1'b1, exp_code: '0,
                                  pred_miss_: 1'b1, jump_miss_: 1'b1};

    entry_t             mem_q    [SRC][FIFO_DEPTH];
    entry_t             mem_d    [SRC][FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q [SRC];
    logic [PTR_W-1:0]   wr_ptr_d [SRC];
    logic [PTR_W-1:0]   rd_ptr_q [SRC];
    logic [PTR_W-1:0]   rd_ptr_d [SRC];
    logic [CNT_W-1:0]   cnt_q    [SRC];
    logic [CNT_W-1:0]   cnt_d    [SRC];
    logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [SRC-1:0]     busy_q, busy_d;
    entry_t             wb_q, wb_d;
    logic               wb_e_q, wb_e_d;

    entry_t             src_ent  [SRC];
    logic [SRC-1:0]     push, pop;
    logic               grant_vld;
    logic [SRC_W-1:0]   grant_idx;

    function automatic logic [SRC_W-1:0] wrap_idx(input logic [SRC_W-1:0] base,
                                                  input int unsigned off);
        return SRC_W'((32'(base) + off) % SRC);
    endfunction

    // Pack each source's inputs and qualify pushes against registered fullness
    always_comb begin
        for (int unsigned i = 0; i < SRC; i++) begin
            src_ent[i] = '{rob_id: src_rob_id[i], data: src_data[i], exp_: src_exp_[i],
                           exp_code: src_exp_code[i], pred_miss_: src_pred_miss_[i],
                           jump_miss_: src_jump_miss_[i]};
            push[i]    = !src_e_[i] && (cnt_q[i] != CNT_W'(FIFO_DEPTH));
        end
    end

    // Round-robin: first non-empty FIFO at or after rr_ptr_q
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int unsigned k = 0; k < SRC; k++) begin
            if (!grant_vld && (cnt_q[wrap_idx(rr_ptr_q, k)] != '0)) begin
                grant_vld = 1'b1;
                grant_idx = wrap_idx(rr_ptr_q, k);
            end
        end
        for (int unsigned i = 0; i < SRC; i++) begin
            pop[i] = grant_vld && (grant_idx == SRC_W'(i));
        end
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        rr_ptr_d = rr_ptr_q;
        wb_d     = wb_q;
        wb_e_d   = 1'b1;
        busy_d   = '0;

        if (!flush_) begin
            for (int unsigned i = 0; i < SRC; i++) begin
                wr_ptr_d[i] = '0;
                rd_ptr_d[i] = '0;
                cnt_d[i]    = '0;
            end
            rr_ptr_d = '0;
        end else begin
            for (int unsigned i = 0; i < SRC; i++) begin
                if (push[i]) begin
                    mem_d[i][wr_ptr_q[i]] = src_ent[i];
                    wr_ptr_d[i]           = wr_ptr_q[i] + PTR_W'(1);
                end
                if (pop[i]) begin
                    rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
                end
                cnt_d[i] = cnt_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
            end
            if (grant_vld) begin
                wb_d     = mem_q[grant_idx][rd_ptr_q[grant_idx]];
                wb_e_d   = 1'b0;
                rr_ptr_d = wrap_idx(grant_idx, 1);
            end
        end

        for (int unsigned i = 0; i < SRC; i++) begin
            busy_d[i] = (cnt_d[i] == CNT_W'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_) begin
            for (int unsigned i = 0; i < SRC; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
            rr_ptr_q <= '0;
            busy_q   <= '0;
            wb_q     <= WB_RST;
            wb_e_q   <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
            busy_q   <= busy_d;
            wb_q     <= wb_d;
            wb_e_q   <= wb_e_d;
        end
    end

    // Payload storage carries no reset; validity lives in the counters
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign src_busy      = busy_q;
    assign wb_e_         = wb_e_q;
    assign wb_rob_id     = wb_q.rob_id;
    assign wb_data       = wb_q.data;
    assign wb_exp_       = wb_q.exp_;
    assign wb_exp_code   = wb_q.exp_code;
    assign wb_pred_miss_ = wb_q.pred_miss_;
    assign wb_jump_miss_ = wb_q.jump_miss_;

    generate
        if (CHK_PUSH_BUSY) begin : g_chk
            for (genvar i = 0; i < SRC; i++) begin : g_src
                a_no_push_busy: assert property (@(posedge clk) disable iff (!reset_ || !flush_)
                    !(!src_e_[i] && busy_q[i]));
            end
        end
    endgenerate

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: queue-based reference model feeds a scoreboard that a
// negedge monitor drains against the writeback port.
module tb_wb_arbiter;

    localparam int DW = 32;
    localparam int RD = 16;
    localparam int RW = 4;
    localparam int NS = 3;
    localparam int FD = 4;
    localparam int EW = 4;
    localparam logic [DW-1:0] FAIR_TAG = 32'hFA1F_0002;

    typedef struct packed {
        logic [RW-1:0] rob;
        logic [DW-1:0] data;
        logic          exp_;
        logic [EW-1:0] code;
        logic          pm_;
        logic          jm_;
    } ent_t;

    typedef struct {
        ent_t e;
        int   cyc;
    } sb_t;

    localparam ent_t RST_ENT = '{rob: '0, data: '0, exp_: 1'b1, code: '0, pm_: 1'b1, jm_: 1'b1};

    logic                    clk = 1'b0;
    logic                    reset_, flush_;
    logic [NS-1:0]           src_e_;
    logic [NS-1:0][RW-1:0]   src_rob_id;
    logic [NS-1:0][DW-1:0]   src_data;
    logic [NS-1:0]           src_exp_;
    logic [NS-1:0][EW-1:0]   src_exp_code;
    logic [NS-1:0]           src_pred_miss_, src_jump_miss_;
    logic [NS-1:0]           src_busy;
    logic                    wb_e_;
    logic [RW-1:0]           wb_rob_id;
    logic [DW-1:0]           wb_data;
    logic                    wb_exp_;
    logic [EW-1:0]           wb_exp_code;
    logic                    wb_pred_miss_, wb_jump_miss_;

    always #5 clk = ~clk;

    wb_arbiter #(
        .DATA(DW), .ROB_DEPTH(RD), .SRC(NS), .FIFO_DEPTH(FD), .EXP_W(EW), .CHK_PUSH_BUSY(1'b0)
    ) dut (
        .clk(clk), .reset_(reset_), .flush_(flush_),
        .src_e_(src_e_), .src_rob_id(src_rob_id), .src_data(src_data),
        .src_exp_(src_exp_), .src_exp_code(src_exp_code),
        .src_pred_miss_(src_pred_miss_), .src_jump_miss_(src_jump_miss_),
        .src_busy(src_busy), .wb_e_(wb_e_), .wb_rob_id(wb_rob_id), .wb_data(wb_data),
        .wb_exp_(wb_exp_), .wb_exp_code(wb_exp_code),
        .wb_pred_miss_(wb_pred_miss_), .wb_jump_miss_(wb_jump_miss_)
    );

    // Reference model state: one queue per source, round-robin start, expectations
    ent_t          mq [NS][$];
    int            rr;
    int            cyc;
    sb_t           sb [$];
    ent_t          last_wb;
    logic [NS-1:0] mbusy;
    bit            mon_on;
    bit            busy1_seen;
    int            fair_push_cyc;
    int            fair_wb_cyc;
    int            n_checks;
    int            n_pass;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, want);
    endtask

    function automatic ent_t src_ent(input int i);
        return '{rob: src_rob_id[i], data: src_data[i], exp_: src_exp_[i], code: src_exp_code[i],
                 pm_: src_pred_miss_[i], jm_: src_jump_miss_[i]};
    endfunction

    // Advance one posedge and apply the behavioural rules to the model
    task automatic step();
        int   g;
        int   idx;
        bit   full [NS];
        sb_t  item;
        @(posedge clk);
        cyc++;
        if (!reset_) begin
            for (int i = 0; i < NS; i++) mq[i].delete();
            rr = 0;
            sb.delete();
            last_wb = RST_ENT;
        end else if (!flush_) begin
            for (int i = 0; i < NS; i++) mq[i].delete();
            rr = 0;
        end else begin
            g = -1;
            for (int k = 0; k < NS; k++) begin
                idx = (rr + k) % NS;
                if (g < 0 && mq[idx].size() > 0) g = idx;
            end
            for (int i = 0; i < NS; i++) full[i] = (mq[i].size() >= FD);
            if (g >= 0) begin
                item.e   = mq[g].pop_front();
                item.cyc = cyc;
                sb.push_back(item);
                rr = (g + 1) % NS;
            end
            for (int i = 0; i < NS; i++)
                if (!src_e_[i] && !full[i]) mq[i].push_back(src_ent(i));
        end
        for (int i = 0; i < NS; i++) mbusy[i] = (mq[i].size() == FD);
    endtask

    // Entered and left at a negedge
    task automatic tick(input logic [NS-1:0] e_, input logic fl_);
        src_e_ = e_;
        flush_ = fl_;
        step();
        @(negedge clk);
        src_e_ = '1;
        flush_ = 1'b1;
    endtask

    task automatic set_src(input int i, input logic [RW-1:0] rob, input logic [DW-1:0] d,
                           input logic ex, input logic [EW-1:0] code, input logic pm,
                           input logic jm);
        src_rob_id[i]     = rob;
        src_data[i]       = d;
        src_exp_[i]       = ex;
        src_exp_code[i]   = code;
        src_pred_miss_[i] = pm;
        src_jump_miss_[i] = jm;
    endtask

    task automatic rand_src(input int i);
        set_src(i, RW'($urandom), $urandom, ($urandom_range(0, 7) != 0), EW'($urandom),
                ($urandom_range(0, 5) != 0), ($urandom_range(0, 5) != 0));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick('1, 1'b1);
    endtask

    always @(negedge clk) begin : monitor
        ent_t act;
        sb_t  item;
        bit   ev;
        if (mon_on) begin
            act = {wb_rob_id, wb_data, wb_exp_, wb_exp_code, wb_pred_miss_, wb_jump_miss_};
            while (sb.size() > 0 && sb[0].cyc < cyc) void'(sb.pop_front());
            ev = (sb.size() > 0) && (sb[0].cyc == cyc);
            chk("wb_e_", 64'(wb_e_), 64'(!ev));
            if (ev) begin
                item = sb.pop_front();
                chk("wb_bundle", 64'(act), 64'(item.e));
                last_wb = item.e;
                if (wb_e_ == 1'b0 && wb_data == FAIR_TAG) fair_wb_cyc = cyc;
            end else begin
                chk("wb_hold", 64'(act), 64'(last_wb));
            end
            chk("src_busy", 64'(src_busy), 64'(mbusy));
            if (src_busy[1]) busy1_seen = 1'b1;
        end
    end

    initial begin
        n_checks = 0; n_pass = 0; cyc = 0; rr = 0;
        mon_on = 1'b0; busy1_seen = 1'b0; fair_push_cyc = -1; fair_wb_cyc = -1;
        last_wb = RST_ENT; mbusy = '0;
        reset_ = 1'b0; flush_ = 1'b1; src_e_ = '1;
        for (int i = 0; i < NS; i++) set_src(i, '0, '0, 1'b1, '0, 1'b1, 1'b1);

        @(negedge clk);
        step();
        step();
        mon_on = 1'b1;
        @(negedge clk);
        chk("rst_wb_e_", 64'(wb_e_), 64'(1));
        chk("rst_rob_data", 64'({wb_rob_id, wb_data, wb_exp_code}), 64'(0));
        chk("rst_flags", 64'({wb_exp_, wb_pred_miss_, wb_jump_miss_}), 64'(3'b111));
        chk("rst_busy", 64'(src_busy), 64'(0));
        reset_ = 1'b1;
        idle(2);

        // Single push from source 0
        set_src(0, 4'd5, 32'hDEADBEEF, 1'b1, '0, 1'b1, 1'b1);
        tick(3'b110, 1'b1);
        idle(4);

        // Flush re-centres rr, then three simultaneous completions, twice
        tick('1, 1'b0);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NS; i++)
                set_src(i, RW'(3 * r + i + 1), 32'hC0DE_0000 + DW'(3 * r + i), 1'b1, '0, 1'b1, 1'b1);
            tick(3'b000, 1'b1);
            idle(5);
        end

        // Fairness: source 0 streams, source 2 pushes one tagged entry
        for (int c = 0; c < 10; c++) begin
            set_src(0, RW'(c), 32'h1000 + DW'(c), 1'b1, '0, 1'b1, 1'b1);
            set_src(2, 4'd7, FAIR_TAG, 1'b1, '0, 1'b1, 1'b1);
            tick((c == 3) ? 3'b010 : 3'b110, 1'b1);
            if (c == 3) fair_push_cyc = cyc;
        end
        idle(6);
        chk("fair_wait", 64'(fair_wb_cyc >= 0 && (fair_wb_cyc - fair_push_cyc) <= 3), 64'(1));

        // Source 1 alone never fills while draining
        busy1_seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            set_src(1, RW'(c), 32'hB000 + DW'(c), 1'b1, '0, 1'b1, 1'b1);
            tick(3'b101, 1'b1);
        end
        idle(4);
        chk("busy1_quiet", 64'(busy1_seen), 64'(0));

        // Saturate all sources; source 1 keeps pushing past full
        busy1_seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            for (int i = 0; i < NS; i++) set_src(i, RW'(c), 32'h5000 + DW'(16 * i + c), 1'b1, '0, 1'b1, 1'b1);
            tick({mbusy[2], 1'b0, mbusy[0]}, 1'b1);
        end
        idle(16);
        chk("busy1_seen", 64'(busy1_seen), 64'(1));

        // Flush with three entries queued, then a fresh push
        for (int i = 0; i < NS; i++) set_src(i, RW'(i + 10), 32'hF100 + DW'(i), 1'b1, '0, 1'b1, 1'b1);
        tick(3'b000, 1'b1);
        tick('1, 1'b0);
        idle(3);
        set_src(2, 4'd12, 32'hAF7E_0001, 1'b1, '0, 1'b1, 1'b1);
        tick(3'b011, 1'b1);
        idle(4);

        // Exception flags beside a clean entry
        set_src(0, 4'd8, 32'h0000_0C1E, 1'b1, '0, 1'b1, 1'b1);
        set_src(2, 4'd9, 32'hE0E0_0002, 1'b0, 4'h2, 1'b0, 1'b1);
        tick(3'b010, 1'b1);
        idle(4);

        // Randomised traffic with occasional flush, reset and over-full pushes
        for (int c = 0; c < 600; c++) begin
            logic [NS-1:0] e;
            for (int i = 0; i < NS; i++) begin
                rand_src(i);
                e[i] = ($urandom_range(0, 99) < 45) ? 1'b0 : 1'b1;
                if (mbusy[i] && $urandom_range(0, 7) != 0) e[i] = 1'b1;
            end
            if ($urandom_range(0, 199) == 0) reset_ = 1'b0;
            tick(e, ($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1);
            reset_ = 1'b1;
        end
        idle(20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
